// File: rtl/instr_prefetch_if.sv
// Fetch-side bus of the prefetch unit: redirect/stall controls, instruction-memory
// port and the decode-facing queue head.
interface instr_prefetch_if #(
  parameter int ADDR_W  = 32,
  parameter int IMEM_AW = 13,
  parameter int DEPTH   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Decode handshake: the head entry transfers in any cycle where o_valid and
  // i_ready are both high; o_pc/o_instr must hold steady while o_valid is high
  // and i_ready is low, and o_valid never depends on i_ready.
  logic               i_fetch_en;
  logic               i_redirect;
  logic [ADDR_W-1:0]  i_redirect_pc;
  logic               o_imem_en;
  logic [IMEM_AW-1:0] o_imem_addr;
  logic [31:0]        i_imem_rdata;
  logic               o_valid;
  logic               i_ready;
  logic [ADDR_W-1:0]  o_pc;
  logic [31:0]        o_instr;
  logic [CW-1:0]      o_count;

  modport master (
    input  i_fetch_en, i_redirect, i_redirect_pc, i_imem_rdata, i_ready,
    output o_imem_en, o_imem_addr, o_valid, o_pc, o_instr, o_count
  );

  modport slave (
    output i_fetch_en, i_redirect, i_redirect_pc, i_imem_rdata, i_ready,
    input  o_imem_en, o_imem_addr, o_valid, o_pc, o_instr, o_count
  );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: owns the fetch PC, issues 1-cycle-latency reads and
// buffers {pc, instr} pairs in a DEPTH-entry queue drained by decode.
module instr_prefetch #(
  parameter int              ADDR_W   = 32,
  parameter int              IMEM_AW  = 13,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic               i_clk,
  input logic               i_rst_n,
  instr_prefetch_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              inflight;
  logic              kill;

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [31:0]       instr_mem [DEPTH];

  logic              pop;
  logic              push;
  logic              push_en;
  logic              issue;
  logic [CW:0]       credit_use;

  // Credit counts the slot reserved by the read already in flight, so a full
  // queue can never receive a response.
  always_comb begin
    pop        = (count != '0) && bus.i_ready;
    push       = inflight && !kill;
    push_en    = push && !bus.i_redirect;
    credit_use = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    issue      = i_rst_n && bus.i_fetch_en && !bus.i_redirect &&
                 (credit_use < (CW+1)'(DEPTH));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
    end else if (bus.i_redirect) begin
      // Redirect drops the queue, this cycle's response and any pop.
      fetch_pc <= bus.i_redirect_pc & ~ADDR_W'(3);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      kill     <= 1'b1;
    end else begin
      kill     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(4);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_en) begin
      pc_mem[wr_ptr]    <= inflight_pc;
      instr_mem[wr_ptr] <= bus.i_imem_rdata;
    end
  end

  assign bus.o_imem_en   = issue;
  assign bus.o_imem_addr = fetch_pc[IMEM_AW-1:0] & ~IMEM_AW'(3);
  assign bus.o_valid     = (count != '0);
  assign bus.o_pc        = bus.o_valid ? pc_mem[rd_ptr]    : '0;
  assign bus.o_instr     = bus.o_valid ? instr_mem[rd_ptr] : '0;
  assign bus.o_count     = count;
endmodule
